nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequencer that performs a wide binary addition by time-sharing one 4-bit ripple-carry adder slice over successive nibbles of two operands, least-significant nibble first. It sits between the operand/keypad capture logic and the FND display path. It latches operands on a start request, runs the slice once per clock with a registered carry, and presents the full-width sum, carry-out and signed overflow with a done pulse.

## Interface
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..8.
- i_clk  input  1  system clock, all state on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  request; sampled only in IDLE or DONE.
- i_a  input  W  operand A, unsigned or two's complement.
- i_b  input  W  operand B.
- i_carry_in  input  1  carry into nibble 0.
- o_busy  output  1  high while slices are being computed.
- o_done  output  1  one-cycle pulse when o_sum/o_carry/o_overflow are updated.
- o_sum  output  W  registered result, A+B+cin mod 2^W.
- o_carry  output  1  carry out of top nibble.
- o_overflow  output  1  signed overflow: A[W-1]==B[W-1] and o_sum[W-1]!=A[W-1].

## Operation
- One internal instance of the 4-bit adder slice; slice inputs are a-reg nibble 0, b-reg nibble 0, carry register; no other adder logic.
- Registers: a_reg, b_reg (W each, right-shifting by 4), carry_reg, acc_reg (W, fills from top), nibble counter (ceil log2 NIBBLES bits), state.
- States: IDLE, RUN, DONE.
- IDLE: o_busy=0. i_start=1 -> load a_reg=i_a, b_reg=i_b, carry_reg=i_carry_in, counter=0, capture sign bits of i_a/i_b; go RUN.
- RUN: o_busy=1. Each cycle: acc_reg <= {slice_sum, acc_reg[W-1:4]}; carry_reg <= slice_carry; a_reg, b_reg shift right 4; counter+1. On counter==NIBBLES-1: load o_sum with the final shifted acc value, o_carry=slice_carry, o_overflow from captured signs and final sum MSB; go DONE.
- DONE: o_done=1 for exactly this cycle, o_busy=0. i_start=1 here is accepted exactly as in IDLE (back-to-back); else go IDLE.
- i_start while RUN: ignored, operands not re-sampled, no queuing.
- i_a/i_b/i_carry_in only sampled at acceptance; later changes have no effect on the running add.
- o_sum/o_carry/o_overflow change only on entry to DONE; they hold through IDLE and through a subsequent RUN until its completion.

## Timing
- Reset (async assert, released synchronously by clock): state=IDLE, o_busy=0, o_done=0, o_sum=0, o_carry=0, o_overflow=0, all internal regs 0.
- Reset during RUN or DONE: abort immediately, outputs to reset values, no done pulse.
- Acceptance edge = E0 (i_start high in cycle 0). o_busy high cycles 1..NIBBLES. Results and o_done visible in cycle NIBBLES+1. Latency start->done = NIBBLES+1 cycles (5 for default).
- Throughput with i_start held high: one result per NIBBLES+1 cycles.
- Carry chain register boundary: slice carry-out from nibble k is applied to nibble k+1 in the next cycle only; no combinational path from i_* to outputs.
- Wrap: sum is modulo 2^W; top carry reported on o_carry, never folded back.

## Test plan
- NIBBLES=4, A=0x1234, B=0x0FFF, cin=0, start pulse -> o_busy cycles 1-4, o_done cycle 5, o_sum=0x2233, o_carry=0, o_overflow=0.
- A=0xFFFF, B=0x0001, cin=0 -> o_sum=0x0000, o_carry=1, o_overflow=0; A=0xFFFF, B=0x0000, cin=1 -> same result (carry-in path).
- A=0x7FFF, B=0x0001 -> o_sum=0x8000, o_carry=0, o_overflow=1; A=0x8000, B=0x8000 -> 0x0000, o_carry=1, o_overflow=1.
- Start accepted with A=0x0001,B=0x0001; pulse i_start again and change i_a to 0xFFFF in cycles 2-3 -> single done, o_sum=0x0002, no second run.
- i_start held high continuously with A=0x0010,B=0x0020 -> o_done in cycles 5, 10, 15; o_sum=0x0030 each time; o_busy low only in done cycles.
- Assert i_reset in cycle 3 of a run -> all outputs 0 same cycle, state IDLE, no o_done; next start completes normally with correct sum.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: wide adder built by time-sharing one 4-bit slice LSB nibble first
module nibble_adder_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [4*NIBBLES-1:0] i_a,
  input  logic [4*NIBBLES-1:0] i_b,
  input  logic                 i_carry_in,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [4*NIBBLES-1:0] o_sum,
  output logic                 o_carry,
  output logic                 o_overflow
);
  localparam int W = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [W-1:0] a_reg, b_reg, acc_reg;
  logic [CW-1:0] cnt;
  logic carry_reg, sign_a, sign_b, slice_carry;
  logic [3:0] slice_sum;
  logic last;
  nibble_adder_slice u_slice (
    .a(a_reg[3:0]),
    .b(b_reg[3:0]),
    .cin(carry_reg),
    .sum(slice_sum),
    .cout(slice_carry)
  );
  assign last = cnt == CW'(NIBBLES - 1);
  // Results are loaded from the final shifted accumulator so they change only on entry to DONE
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc_reg <= '0;
      cnt <= '0;
      carry_reg <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_sum <= '0;
      o_carry <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          acc_reg <= {slice_sum, acc_reg[W-1:4]};
          carry_reg <= slice_carry;
          a_reg <= a_reg >> 4;
          b_reg <= b_reg >> 4;
          cnt <= cnt + CW'(1);
          if (last) begin
            o_sum <= {slice_sum, acc_reg[W-1:4]};
            o_carry <= slice_carry;
            o_overflow <= (sign_a == sign_b) && (slice_sum[3] != sign_a);
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          o_done <= 1'b0;
          state <= i_start ? RUN : IDLE;
          o_busy <= i_start;
          if (i_start) begin
            a_reg <= i_a;
            b_reg <= i_b;
            carry_reg <= i_carry_in;
            cnt <= '0;
            sign_a <= i_a[W-1];
            sign_b <= i_b[W-1];
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: scoreboard bench with arithmetic reference model and random operands
module tb_nibble_serial_adder_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;
  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
    int           cyc;
  } exp_t;
  logic i_clk = 0, i_reset = 1, i_start = 0, i_carry_in = 0;
  logic [W-1:0] i_a = '0, i_b = '0;
  logic o_busy, o_done, o_carry, o_overflow;
  logic [W-1:0] o_sum;
  int total = 0, bad = 0, cyc = 0;
  exp_t sb[$];
  exp_t hold = '0;

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_a(i_a), .i_b(i_b),
    .i_carry_in(i_carry_in), .o_busy(o_busy), .o_done(o_done), .o_sum(o_sum),
    .o_carry(o_carry), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    longint full, sa, sb_, t;
    exp_t e;
    full = longint'(a) + longint'(b) + longint'(cin);
    sa = a >= (1 << (W - 1)) ? longint'(a) - (longint'(1) << W) : longint'(a);
    sb_ = b >= (1 << (W - 1)) ? longint'(b) - (longint'(1) << W) : longint'(b);
    t = sa + sb_ + longint'(cin);
    e.sum = full[W-1:0];
    e.c = full[W];
    e.v = (t > (longint'(1) << (W - 1)) - 1) || (t < -(longint'(1) << (W - 1)));
    e.cyc = 0;
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: pops on every done pulse, otherwise results must hold the last completed value
  always @(negedge i_clk) begin
    if (i_reset) hold = '0;
    else if (o_done) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", o_sum, e.sum);
        check("carry", o_carry, e.c);
        check("overflow", o_overflow, e.v);
        check("done_cycle", cyc, e.cyc);
        check("busy_in_done", o_busy, 0);
        hold = e;
      end
    end else
      check("hold", {o_sum, o_carry, o_overflow}, {hold.sum, hold.c, hold.v});
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t e;
    i_a = a; i_b = b; i_carry_in = cin; i_start = 1;
    @(negedge i_clk);
    e = model(a, b, cin);
    e.cyc = cyc + N;
    sb.push_back(e);
    check("busy_cycle1", o_busy, 1);
    i_start = 0;
    i_a = W'($urandom); i_b = W'($urandom); i_carry_in = 1'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge i_clk);
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge i_clk);
  endtask

  initial begin
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_sum", {o_sum, o_carry, o_overflow}, 0);
    @(negedge i_clk); @(negedge i_clk);
    i_reset = 0;
    @(negedge i_clk);
    start_op(16'h1234, 16'h0FFF, 0);
    for (int i = 2; i <= N; i++) begin
      @(negedge i_clk);
      check("busy_run", o_busy, 1);
    end
    wait_idle();
    start_op(16'hFFFF, 16'h0001, 0); wait_idle();
    start_op(16'hFFFF, 16'h0000, 1); wait_idle();
    start_op(16'h7FFF, 16'h0001, 0); wait_idle();
    start_op(16'h8000, 16'h8000, 0); wait_idle();
    // Start pulses and operand changes during RUN must be ignored
    start_op(16'h0001, 16'h0001, 0);
    @(negedge i_clk);
    i_start = 1; i_a = 16'hFFFF;
    @(negedge i_clk);
    i_start = 0;
    wait_idle();
    repeat (8) @(negedge i_clk);
    // Start held high: one result every N+1 cycles, busy low only in done cycles
    i_a = 16'h0010; i_b = 16'h0020; i_carry_in = 0; i_start = 1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      @(negedge i_clk);
      e = model(16'h0010, 16'h0020, 0);
      e.cyc = cyc + N;
      sb.push_back(e);
      for (int j = 0; j < N; j++) begin
        check("busy_held", o_busy, 1);
        @(negedge i_clk);
      end
    end
    i_start = 0;
    wait_idle();
    // Reset in cycle 3 of a run aborts it with no done pulse
    start_op(16'h4321, 16'h1111, 1);
    @(negedge i_clk);
    #2 i_reset = 1;
    #1;
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_outs", {o_sum, o_carry, o_overflow}, 0);
    sb.delete();
    @(negedge i_clk);
    #2 i_reset = 0;
    repeat (N + 3) @(negedge i_clk);
    start_op(16'h4321, 16'h1111, 1); wait_idle();
    for (int k = 0; k < 40; k++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom));
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
